// File: rtl/fadd_result_queue.sv
// fadd_result_queue: credit-metered capture queue pairing fixed-latency fadd results
// with their issue tags and presenting them to writeback via valid/ready.
module fadd_result_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  parameter int LAT   = 3
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [TAG_W-1:0]           issue_tag,
  output logic                       issue_ready,
  output logic                       fadd_start,
  input  logic                       res_valid_in,
  input  logic [31:0]                res_data_in,
  output logic                       wb_valid,
  output logic [31:0]                wb_data,
  output logic [TAG_W-1:0]           wb_tag,
  input  logic                       wb_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_overflow,
  output logic                       err_misalign
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [CW-1:0]    credits_q, credits_d, count_q, count_d;
  logic [AW-1:0]    rd_q, wr_q;
  logic [LAT-1:0]   pipe_v_q;
  logic [TAG_W-1:0] pipe_t_q [LAT];
  logic [31:0]      mem_d_q [DEPTH];
  logic [TAG_W-1:0] mem_t_q [DEPTH];
  logic             ovf_q, mis_q;
  logic             pop, full, push_try, push;
  assign issue_ready  = credits_q != '0;
  // gated by reset so no add launches while the queue is being cleared
  assign fadd_start   = issue_valid & issue_ready & rst;
  assign wb_valid     = count_q != '0;
  assign pop          = wb_valid & wb_ready;
  assign full         = count_q == CW'(DEPTH);
  assign push_try     = res_valid_in & pipe_v_q[LAT-1];
  assign push         = push_try & (!full | pop);
  assign wb_data      = mem_d_q[rd_q];
  assign wb_tag       = mem_t_q[rd_q];
  assign count        = count_q;
  assign err_overflow = ovf_q;
  assign err_misalign = mis_q;
  always_comb begin
    credits_d = credits_q - CW'(fadd_start) + CW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      credits_q <= CW'(DEPTH);
      count_q   <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      pipe_v_q  <= '0;
      ovf_q     <= 1'b0;
      mis_q     <= 1'b0;
      for (int i = 0; i < LAT; i++) pipe_t_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d_q[i] <= '0;
        mem_t_q[i] <= '0;
      end
    end else begin
      credits_q   <= credits_d;
      count_q     <= count_d;
      pipe_v_q    <= {pipe_v_q[LAT-2:0], fadd_start};
      pipe_t_q[0] <= issue_tag;
      for (int i = 1; i < LAT; i++) pipe_t_q[i] <= pipe_t_q[i-1];
      if (push) begin
        mem_d_q[wr_q] <= res_data_in;
        mem_t_q[wr_q] <= pipe_t_q[LAT-1];
        wr_q          <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      ovf_q <= ovf_q | (push_try & full & !pop);
      mis_q <= mis_q | (pipe_v_q[LAT-1] & !res_valid_in);
    end
  end
endmodule

// File: tb/tb_fadd_result_queue.sv
// tb_fadd_result_queue: directed bench with a behavioural 3-cycle fadd in front of the queue.
module tb_fadd_result_queue;
  localparam int TAG_W = 5;
  logic             sys_clk = 1'b0;
  logic             rst = 1'b0;
  logic             issue_valid = 1'b0;
  logic [TAG_W-1:0] issue_tag = '0;
  logic             issue_ready, fadd_start, wb_valid, err_overflow, err_misalign;
  logic             res_valid_in;
  logic [31:0]      res_data_in, wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_ready = 1'b0;
  logic [2:0]       count;
  int               n_chk = 0, n_err = 0;
  // fadd stand-in: not reset, carries the hand-computed sum of each launched add
  logic [2:0]       fv = '0;
  logic [31:0]      fd [3] = '{default: '0};
  logic [31:0]      op_y = '0;
  logic             kill = 1'b0, inj = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) begin
    fv    <= {fv[1:0], fadd_start};
    fd[0] <= op_y;
    fd[1] <= fd[0];
    fd[2] <= fd[1];
  end
  assign res_valid_in = inj | (fv[2] & !kill);
  assign res_data_in  = fd[2];
  fadd_result_queue #(.DEPTH(4), .TAG_W(TAG_W), .LAT(3)) dut (
    .sys_clk(sys_clk), .rst(rst), .issue_valid(issue_valid), .issue_tag(issue_tag),
    .issue_ready(issue_ready), .fadd_start(fadd_start), .res_valid_in(res_valid_in),
    .res_data_in(res_data_in), .wb_valid(wb_valid), .wb_data(wb_data), .wb_tag(wb_tag),
    .wb_ready(wb_ready), .count(count), .err_overflow(err_overflow), .err_misalign(err_misalign)
  );
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic burst(input int n, input logic [TAG_W-1:0] base, output int acc);
    logic [TAG_W-1:0] t;
    t = base;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      issue_valid = 1'b1;
      issue_tag = t;
      op_y = 32'h1000_0000 + 32'(t);
      #1;
      if (fadd_start) begin
        acc++;
        t++;
      end
      step();
    end
    issue_valid = 1'b0;
  endtask
  task automatic check_idle(input string nm);
    chk({nm, "_issue_ready"}, 32'(issue_ready), 1);
    chk({nm, "_wb_valid"}, 32'(wb_valid), 0);
    chk({nm, "_count"}, 32'(count), 0);
    chk({nm, "_err_ovf"}, 32'(err_overflow), 0);
    chk({nm, "_err_mis"}, 32'(err_misalign), 0);
  endtask
  initial begin
    int acc, nt, et;
    logic stall;
    // reset values and fadd_start suppression during reset
    step();
    issue_valid = 1'b1;
    #1;
    check_idle("rst");
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_tag", 32'(wb_tag), 0);
    chk("rst_fadd_start", 32'(fadd_start), 0);
    issue_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    // single issue: 1.0 + 2.0 = 3.0
    wb_ready = 1'b1;
    issue_valid = 1'b1;
    issue_tag = 5'd5;
    op_y = 32'h4040_0000;
    #1;
    chk("single_start", 32'(fadd_start), 1);
    step();
    issue_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("single_wait_valid", 32'(wb_valid), 0);
      step();
    end
    chk("single_valid", 32'(wb_valid), 1);
    chk("single_data", wb_data, 32'h4040_0000);
    chk("single_tag", 32'(wb_tag), 5);
    chk("single_count1", 32'(count), 1);
    step();
    chk("single_count0", 32'(count), 0);
    chk("single_drained", 32'(wb_valid), 0);
    // back-to-back: 8 issues through 4 credits
    nt = 0;
    et = 0;
    stall = 1'b0;
    for (int c = 0; c < 40; c++) begin
      issue_valid = nt < 8;
      issue_tag = TAG_W'(nt);
      op_y = 32'h1000_0000 + 32'(nt);
      #1;
      if (!issue_ready) stall = 1'b1;
      if (fadd_start) nt++;
      if (wb_valid & wb_ready) begin
        chk("b2b_tag", 32'(wb_tag), 32'(et));
        chk("b2b_data", wb_data, 32'h1000_0000 + 32'(et));
        et++;
      end
      step();
    end
    issue_valid = 1'b0;
    chk("b2b_total", 32'(et), 8);
    chk("b2b_stalled", 32'(stall), 1);
    check_idle("b2b_end");
    // backpressure: only 4 of 6 accepted, head held stable
    wb_ready = 1'b0;
    burst(6, 5'd10, acc);
    chk("bp_accepted", 32'(acc), 4);
    step();
    step();
    step();
    chk("bp_count", 32'(count), 4);
    chk("bp_issue_ready", 32'(issue_ready), 0);
    chk("bp_head_tag", 32'(wb_tag), 10);
    step();
    chk("bp_head_stable_tag", 32'(wb_tag), 10);
    chk("bp_head_stable_data", wb_data, 32'h1000_000A);
    wb_ready = 1'b1;
    #1;
    chk("bp_pop_ready0", 32'(issue_ready), 0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_pop_tag", 32'(wb_tag), 32'(10 + i));
      chk("bp_pop_valid", 32'(wb_valid), 1);
      step();
      if (i == 0) chk("bp_ready_after_pop", 32'(issue_ready), 1);
    end
    check_idle("bp_end");
    // issue attempt at zero credits while popping
    wb_ready = 1'b0;
    burst(4, 5'd20, acc);
    chk("zc_fill", 32'(acc), 4);
    step();
    step();
    step();
    chk("zc_count", 32'(count), 4);
    issue_valid = 1'b1;
    issue_tag = 5'd24;
    op_y = 32'h1000_0018;
    wb_ready = 1'b1;
    #1;
    chk("zc_blocked", 32'(fadd_start), 0);
    chk("zc_head", 32'(wb_tag), 20);
    step();
    chk("zc_ready_back", 32'(issue_ready), 1);
    chk("zc_accept", 32'(fadd_start), 1);
    chk("zc_head2", 32'(wb_tag), 21);
    step();
    issue_valid = 1'b0;
    #1;
    chk("zc_credit_kept", 32'(issue_ready), 1);
    et = 22;
    for (int c = 0; c < 10; c++) begin
      if (wb_valid) begin
        chk("zc_drain_tag", 32'(wb_tag), 32'(et));
        et++;
      end
      step();
    end
    chk("zc_drain_total", 32'(et), 25);
    wb_ready = 1'b0;
    burst(6, 5'd1, acc);
    chk("zc_credits_full", 32'(acc), 4);
    wb_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();
    check_idle("zc_end");
    // reset one cycle after two issues; stale fadd pulses must be ignored
    burst(2, 5'd30, acc);
    rst = 1'b0;
    issue_valid = 1'b1;
    #1;
    check_idle("mid_rst");
    chk("mid_rst_start", 32'(fadd_start), 0);
    issue_valid = 1'b0;
    step();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("mid_rst_stale", 32'(wb_valid), 0);
      step();
    end
    check_idle("mid_rst_end");
    // misalign: suppress an expected result
    kill = 1'b1;
    burst(1, 5'd7, acc);
    step();
    step();
    step();
    chk("mis_set", 32'(err_misalign), 1);
    chk("mis_nopush", 32'(wb_valid), 0);
    kill = 1'b0;
    step();
    step();
    chk("mis_sticky", 32'(err_misalign), 1);
    chk("mis_no_ovf", 32'(err_overflow), 0);
    rst = 1'b0;
    #1;
    chk("mis_cleared", 32'(err_misalign), 0);
    step();
    rst = 1'b1;
    step();
    // overflow: inject a push into a full queue with no pop
    wb_ready = 1'b0;
    burst(6, 5'd18, acc);
    step();
    step();
    step();
    chk("ovf_full", 32'(count), 4);
    chk("ovf_pre", 32'(err_overflow), 0);
    inj = 1'b1;
    force dut.pipe_v_q = '1;
    step();
    release dut.pipe_v_q;
    chk("ovf_set", 32'(err_overflow), 1);
    chk("ovf_count", 32'(count), 4);
    step();
    step();
    step();
    inj = 1'b0;
    step();
    chk("ovf_sticky", 32'(err_overflow), 1);
    chk("ovf_count_held", 32'(count), 4);
    chk("ovf_head_tag", 32'(wb_tag), 18);
    chk("ovf_head_data", wb_data, 32'h1000_0012);
    chk("ovf_no_mis", 32'(err_misalign), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fadd_result_queue.md
# fadd_result_queue

Result-capture and writeback buffer placed directly downstream of the 3-stage pipelined `fadd`. `fadd` has no stall input, so this block meters issue with a credit counter: an add is launched only when a queue slot is guaranteed. Each result is paired with the destination tag captured at issue and presented to the core writeback port through a valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, 4: queue entries and initial credits. Power of two, ≥ 2.
- `TAG_W`, 5: destination-register tag width.
- `LAT`, 3: `fadd` latency from `stage1_valid` to `out_valid`, in cycles.

Ports:
- `sys_clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `issue_valid`  in  1  upstream requests an add this cycle.
- `issue_tag`  in  TAG_W  destination tag of the requested add.
- `issue_ready`  out  1  credit available; issue is accepted when `issue_valid & issue_ready`.
- `fadd_start`  out  1  combinational `issue_valid & issue_ready`; drives `fadd.stage1_valid`.
- `res_valid_in`  in  1  from `fadd.out_valid`.
- `res_data_in`  in  32  from `fadd.y`.
- `wb_valid`  out  1  queue head valid.
- `wb_data`  out  32  queue head result.
- `wb_tag`  out  TAG_W  queue head tag.
- `wb_ready`  in  1  writeback consumes the head when `wb_valid & wb_ready`.
- `count`  out  $clog2(DEPTH)+1  queue occupancy.
- `err_overflow`  out  1  sticky: push attempted while full with no pop.
- `err_misalign`  out  1  sticky: expected result missing.

## Operation
- Credit counter (width $clog2(DEPTH)+1), reset to DEPTH. Decrements on accepted issue and increments on writeback pop. If both happen in the same cycle, it is unchanged. `issue_ready = (credits != 0)`.
- Tag pipe: LAT registers of {valid, tag}. Stage 0 loads {`fadd_start`, `issue_tag`} each cycle, and every stage shifts one per cycle. Stage LAT-1 output is aligned with `res_valid_in`.
- Push condition: `res_valid_in & pipe_valid[LAT-1]`. On push, write {`res_data_in`, `pipe_tag[LAT-1]`} at the write pointer.
- If `res_valid_in` is high while `pipe_valid[LAT-1]` is 0, the result is ignored and no error is raised. This covers stale `fadd` outputs after reset, since `fadd` itself is not reset.
- If `pipe_valid[LAT-1]` is 1 while `res_valid_in` is 0, set `err_misalign` and push nothing.
- Full handling: push while full is accepted only if a pop occurs in the same cycle. Otherwise the push is dropped and `err_overflow` is set. This is unreachable under credit control.
- FIFO layout: circular, with read/write pointers of $clog2(DEPTH) bits that wrap naturally. Occupancy is tracked in `count`; full = (`count` == DEPTH), empty = (`count` == 0).
- Outputs: `wb_valid = !empty`. `wb_data` and `wb_tag` show the head entry (show-ahead). They hold stable while `wb_valid & !wb_ready`.
- No bypass: a push into an empty queue becomes visible on `wb_valid` the next cycle.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.

## Timing
- Reset values: `issue_ready`=1, `wb_valid`=0, `wb_data`=0, `wb_tag`=0, `count`=0, `err_overflow`=0, `err_misalign`=0. Also credits=DEPTH, all pipe valids 0, pointers 0.
- `fadd_start` is 0 during reset.
- Reset mid-operation clears everything immediately. In-flight `fadd` results emerging afterwards are discarded per the rule above.
- Issue in cycle N: `res_valid_in` arrives in cycle N+LAT, and `wb_valid` with that entry is high in cycle N+LAT+1.
- A credit freed by a pop in cycle M allows `issue_ready`=1 in cycle M+1.
- Sustained throughput is one add per cycle when `wb_ready` is held high. With DEPTH < LAT+2, issue stalls periodically: DEPTH credits cover a LAT+2-cycle round trip.
- Results leave in issue order. `fadd` is fixed-latency, so ordering follows from the FIFO.

## Test plan
- Single issue: tag=5 with `fadd` fed 0x3F800000+0x40000000, `wb_ready`=1. Expect `wb_valid` 4 cycles after issue, `wb_data`=0x40400000, `wb_tag`=5, `count` 1→0.
- Back-to-back: 8 issues with tags 0..7, `wb_ready`=1, DEPTH=4. Expect all 8 results in tag order 0..7. Expect `issue_ready` to drop once credits reach 0, and no error flags.
- Backpressure: `wb_ready`=0 and 6 issue attempts. Expect exactly 4 accepted, `count`=4, `issue_ready`=0, and head data stable. Then `wb_ready`=1: expect 4 pops in order and `issue_ready`=1 the cycle after the first pop.
- Simultaneous pop and issue at credits=0 with a pop occurring: `issue_ready` returns the next cycle and credits stay consistent. After draining, credits=DEPTH.
- Reset mid-flight: assert `rst`=0 one cycle after 2 issues, then release. Expect all outputs at reset values. The 2 stale `out_valid` pulses are ignored, `count`=0, and no errors.
- Error injection: force `res_valid_in`=0 where a result is expected → `err_misalign`=1 (sticky). Force a push into a full queue with `wb_ready`=0 → `err_overflow`=1 and `count` stays 4.
